// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared core constants and the fetch-state encoding
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/if_fifo.sv
// rtl/if_fifo.sv - fetched {pc, inst} storage with a registered head so readers never see push data combinationally
module if_fifo
    import rv_pkg::*;
#(
    parameter int WIDTH = 2 * XLEN,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           head_data
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_ptr_next;
    logic [CW-1:0]    count_after_pop;
    logic [CW-1:0]    count_next;
    logic             do_pop;

    always_comb begin
        do_pop          = pop && (count != '0);
        count_after_pop = count - CW'(do_pop);
        count_next      = count_after_pop + CW'(push);
        rd_ptr_next     = rd_ptr + PW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Head is pre-loaded from the entry that will be at the front next cycle;
    // when the queue drains it keeps showing the last entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            head_data <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            rd_ptr <= rd_ptr_next;
            count  <= count_next;
            if (count_after_pop == '0) begin
                if (push) begin
                    head_data <= push_data;
                end
            end else begin
                head_data <= mem[rd_ptr_next];
            end
        end
    end

endmodule

// File: rtl/if_prefetch_queue.sv
// rtl/if_prefetch_queue.sv - instruction prefetch queue, one outstanding fetch; IF_MISALIGN_CHK_EN adds the misalign flag
module if_prefetch_queue
    import rv_pkg::*;
#(
    parameter int                   BIT_WIDTH = XLEN,
    parameter int                   DEPTH     = 4,
    parameter logic [BIT_WIDTH-1:0] RESET_PC  = BIT_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 imem_req,
    output logic [BIT_WIDTH-1:0] imem_addr,
    input  logic                 imem_gnt,
    input  logic                 imem_rvalid,
    input  logic [BIT_WIDTH-1:0] imem_rdata,
    input  logic                 redirect,
    input  logic [BIT_WIDTH-1:0] redirect_pc,
    input  logic                 stall,
`ifdef IF_MISALIGN_CHK_EN
    output logic                 misalign,
`endif
    output logic                 if_valid,
    output logic [BIT_WIDTH-1:0] if_pc,
    output logic [BIT_WIDTH-1:0] if_inst
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e           state;
    fetch_state_e           state_next;
    logic [BIT_WIDTH-1:0]   fetch_pc;
    logic [BIT_WIDTH-1:0]   addr_q;
    logic [BIT_WIDTH-1:0]   target_pc;
    logic                   kill_q;
    logic                   full;
    logic                   push;
    logic                   pop;
    logic [CW-1:0]          count;
    logic [2*BIT_WIDTH-1:0] head_data;

    assign target_pc = {redirect_pc[BIT_WIDTH-1:2], 2'b00};
    assign full      = (count == CW'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A redirect seen in REQ (now or earlier) turns the granted fetch into a DROP.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (redirect || !full) state_next = REQ;
            REQ:  if (imem_gnt) state_next = (redirect || kill_q) ? DROP : WAIT;
            WAIT: begin
                if (redirect) begin
                    state_next = imem_rvalid ? IDLE : DROP;
                end else if (imem_rvalid) begin
                    state_next = IDLE;
                end
            end
            DROP: if (imem_rvalid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        imem_req = (state == REQ);
        push     = (state == WAIT) && imem_rvalid && !redirect;
        pop      = if_valid && !stall && !redirect;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            addr_q   <= '0;
            kill_q   <= 1'b0;
        end else begin
            if (redirect) begin
                fetch_pc <= target_pc;
            end else if ((state == REQ) && imem_gnt && !kill_q) begin
                fetch_pc <= fetch_pc + BIT_WIDTH'(4);
            end
            if ((state == IDLE) && (state_next == REQ)) begin
                addr_q <= redirect ? target_pc : fetch_pc;
            end
            if (state == REQ) begin
                kill_q <= imem_gnt ? 1'b0 : (kill_q || redirect);
            end
        end
    end

`ifdef IF_MISALIGN_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign <= 1'b0;
        end else begin
            misalign <= redirect && (redirect_pc[1:0] != 2'b00);
        end
    end
`else
    logic unused_pc_low;
    assign unused_pc_low = ^redirect_pc[1:0];
`endif

    if_fifo #(
        .WIDTH (2 * BIT_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({addr_q, imem_rdata}),
        .pop       (pop),
        .flush     (redirect),
        .count     (count),
        .head_data (head_data)
    );

    assign imem_addr = addr_q;
    assign if_valid  = (count != '0);
    assign if_pc     = head_data[2*BIT_WIDTH-1:BIT_WIDTH];
    assign if_inst   = head_data[BIT_WIDTH-1:0];

endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb/tb_if_prefetch_queue.sv - randomized bench for if_prefetch_queue against an in-order fetch-stream model
module tb_if_prefetch_queue;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
`ifdef IF_MISALIGN_CHK_EN
    logic        misalign;
`endif

    if_prefetch_queue #(
        .BIT_WIDTH (32),
        .DEPTH     (4),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
`ifdef IF_MISALIGN_CHK_EN
        .misalign    (misalign),
`endif
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_inst     (if_inst)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int          checks = 0;
    int          errors = 0;
    int          gnt_pct = 100;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          gnt_block = 0;
    bit          pend;
    int          cd;
    logic [31:0] pend_addr;
    logic [31:0] exp_pc;
    int          pops;
    int          cyc = 0;
    bit          prev_hold;
    logic [31:0] prev_addr;
    bit          prev_mis;
    logic [31:0] grant_log[$];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // One clock of stimulus: check outputs of this cycle, then drive the
    // controls and the memory responder for it.
    task automatic tick(input bit s, input bit r, input logic [31:0] rpc);
        bit          pend_at_start;
        logic [31:0] a;
        @(negedge clk);
        cyc++;
        a = imem_addr;
        if (pend) begin
            checks++;
            if (imem_req !== 1'b0) begin
                errors++;
                $display("FAIL one_outstanding: imem_req=%b while a response is pending", imem_req);
            end
        end
        if (prev_hold) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
                errors++;
                $display("FAIL req_hold: req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, prev_addr);
            end
        end
        if (imem_req === 1'b1) begin
            checks++;
            if (a[1:0] !== 2'b00) begin
                errors++;
                $display("FAIL addr_align: imem_addr=%h is not word aligned", imem_addr);
            end
        end
        if (if_valid === 1'b1 && !s && !r) begin
            checks++;
            if (if_pc !== exp_pc || if_inst !== memf(exp_pc)) begin
                errors++;
                $display("FAIL pop_order: pc=%h inst=%h, required pc=%h inst=%h", if_pc, if_inst, exp_pc, memf(exp_pc));
            end
            pops++;
            exp_pc = exp_pc + 32'd4;
        end
        if (r) exp_pc = {rpc[31:2], 2'b00};
`ifdef IF_MISALIGN_CHK_EN
        checks++;
        if (misalign !== prev_mis) begin
            errors++;
            $display("FAIL misalign_flag: got %b required %b", misalign, prev_mis);
        end
        prev_mis = r && (rpc[1:0] != 2'b00);
`endif
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        pend_at_start = pend;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (pend) begin
            cd--;
            if (cd == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = memf(pend_addr);
                pend        = 1'b0;
            end
        end
        imem_gnt = 1'b0;
        if (imem_req === 1'b1 && !pend_at_start && !gnt_block && ($urandom_range(99) < gnt_pct)) begin
            imem_gnt  = 1'b1;
            pend      = 1'b1;
            cd        = $urandom_range(lat_max, lat_min);
            pend_addr = imem_addr;
            grant_log.push_back(imem_addr);
        end
        prev_hold = (imem_req === 1'b1) && !imem_gnt;
        prev_addr = imem_addr;
    endtask

    // Reset with a stale gnt/rvalid on the bus, released on a falling edge so
    // the stale rvalid is still present in the first cycle after release.
    task automatic do_reset(input bit check_during);
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        if (check_during) begin
            checks++;
            if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b required 0", imem_req); end
            checks++;
            if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", if_valid); end
            checks++;
            if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h required 0", imem_addr); end
            checks++;
            if (if_pc !== 32'h0 || if_inst !== 32'h0) begin
                errors++;
                $display("FAIL reset_head: pc=%h inst=%h required 0/0", if_pc, if_inst);
            end
`ifdef IF_MISALIGN_CHK_EN
            checks++;
            if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b required 0", misalign); end
`endif
        end
        rst_n     = 1'b1;
        pend      = 1'b0;
        exp_pc    = 32'h0;
        prev_hold = 1'b0;
        prev_mis  = 1'b0;
        pops      = 0;
        grant_log.delete();
    endtask

    task automatic check_first_req();
        tick(1'b1, 1'b0, 32'h0);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL first_req: req=%b addr=%h required 1/00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_reset();
        gnt_pct = 100; lat_min = 1; lat_max = 1; gnt_block = 0;
        do_reset(1'b1);
        check_first_req();
        lat_min = 5; lat_max = 5;
        for (int i = 0; i < 20 && !pend; i++) tick(1'b0, 1'b0, 32'h0);
        lat_min = 1; lat_max = 1;
        do_reset(1'b0);
        check_first_req();
        repeat (30) tick(1'b0, 1'b0, 32'h0);
        checks++;
        if (pops < 2) begin errors++; $display("FAIL reset_mid_drain: pops=%0d required >=2", pops); end
    endtask

    task automatic test_sequence();
        int          first_rv = -1;
        int          first_valid = -1;
        logic [31:0] first_pc = '0;
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        do_reset(1'b0);
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b0, 32'h0);
            if (first_rv < 0 && imem_rvalid === 1'b1) first_rv = cyc;
            if (first_valid < 0 && if_valid === 1'b1) begin first_valid = cyc; first_pc = if_pc; end
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (grant_log.size() <= k || grant_log[k] !== 32'(4 * k)) begin
                errors++;
                $display("FAIL seq_addr%0d: got %h required %h", k, (grant_log.size() > k) ? grant_log[k] : 32'hx, 32'(4 * k));
            end
        end
        checks++;
        if (first_valid < 0 || first_pc !== 32'h0) begin
            errors++;
            $display("FAIL seq_first_pc: got %h required 00000000", first_pc);
        end
        checks++;
        if (first_rv < 0 || first_valid != first_rv + 1) begin
            errors++;
            $display("FAIL seq_latency: valid cycle %0d, required %0d", first_valid, first_rv + 1);
        end
    endtask

    task automatic test_full();
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        do_reset(1'b0);
        repeat (20) tick(1'b1, 1'b0, 32'h0);
        checks++;
        if (grant_log.size() != 4) begin errors++; $display("FAIL full_fetches: got %0d required 4", grant_log.size()); end
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL full_req: got %b required 0", imem_req); end
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_inst !== memf(32'h0)) begin
            errors++;
            $display("FAIL full_head: valid=%b pc=%h inst=%h required 1/00000000/%h", if_valid, if_pc, if_inst, memf(32'h0));
        end
        repeat (40) tick($urandom_range(99) < 30, 1'b0, 32'h0);
        checks++;
        if (pops < 4) begin errors++; $display("FAIL full_drain: pops=%0d required >=4", pops); end
    endtask

    task automatic test_redirect_wait();
        bit found = 0;
        gnt_pct = 100; lat_min = 4; lat_max = 4;
        do_reset(1'b0);
        for (int i = 0; i < 20 && grant_log.size() < 1; i++) tick(1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 32'h100);
        tick(1'b0, 1'b0, 32'h0);
        checks++;
        if (if_valid !== 1'b0) begin errors++; $display("FAIL rw_flush: if_valid=%b required 0", if_valid); end
        for (int i = 0; i < 40 && !found; i++) begin
            tick(1'b1, 1'b0, 32'h0);
            if (if_valid === 1'b1) found = 1;
        end
        checks++;
        if (!found || if_pc !== 32'h100) begin
            errors++;
            $display("FAIL rw_first_valid: found=%0d pc=%h required pc 00000100", found, if_pc);
        end
        checks++;
        if (grant_log.size() < 2 || grant_log[1] !== 32'h100) begin
            errors++;
            $display("FAIL rw_next_addr: got %h required 00000100", (grant_log.size() > 1) ? grant_log[1] : 32'hx);
        end
        lat_min = 1; lat_max = 1;
        repeat (10) tick(1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_redirect_req();
        bit found = 0;
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        do_reset(1'b0);
        for (int i = 0; i < 30 && grant_log.size() < 2; i++) tick(1'b0, 1'b0, 32'h0);
        gnt_block = 1;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(1'b0, 1'b0, 32'h0);
            if (imem_req === 1'b1 && imem_addr === 32'h8) found = 1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL rr_reach_req: req=%b addr=%h required 1/00000008", imem_req, imem_addr); end
        tick(1'b0, 1'b1, 32'h40);
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b0, 32'h0);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
                errors++;
                $display("FAIL rr_hold: req=%b addr=%h required 1/00000008", imem_req, imem_addr);
            end
        end
        gnt_block = 0;
        for (int i = 0; i < 30 && grant_log.size() < 4; i++) tick(1'b0, 1'b0, 32'h0);
        checks++;
        if (grant_log.size() < 4 || grant_log[2] !== 32'h8 || grant_log[3] !== 32'h40) begin
            errors++;
            $display("FAIL rr_addrs: got %h,%h required 00000008,00000040",
                     (grant_log.size() > 2) ? grant_log[2] : 32'hx, (grant_log.size() > 3) ? grant_log[3] : 32'hx);
        end
        pops = 0;
        repeat (20) tick(1'b0, 1'b0, 32'h0);
        checks++;
        if (pops < 1) begin errors++; $display("FAIL rr_resume: pops=%0d required >=1", pops); end
    endtask

    task automatic test_back_to_back();
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        do_reset(1'b0);
        for (int i = 0; i < 30 && grant_log.size() < 3; i++) tick(1'b1, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 32'h0);
        checks++;
        if (imem_rvalid !== 1'b1 || pops != 1) begin
            errors++;
            $display("FAIL b2b_setup: rvalid=%b pops=%0d required 1/1", imem_rvalid, pops);
        end
        repeat (20) tick(1'b1, 1'b0, 32'h0);
        checks++;
        if (grant_log.size() != 5) begin errors++; $display("FAIL b2b_count: fetches=%0d required 5", grant_log.size()); end
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h4) begin
            errors++;
            $display("FAIL b2b_head: valid=%b pc=%h required 1/00000004", if_valid, if_pc);
        end
        repeat (30) tick(1'b0, 1'b0, 32'h0);
        checks++;
        if (pops < 5) begin errors++; $display("FAIL b2b_drain: pops=%0d required >=5", pops); end
    endtask

    task automatic test_wrap();
        int base;
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        do_reset(1'b0);
        repeat (3) tick(1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 32'hFFFF_FFF8);
        base = grant_log.size();
        for (int i = 0; i < 60 && grant_log.size() < base + 5; i++) tick(1'b1, 1'b0, 32'h0);
        checks++;
        if (grant_log.size() < base + 3 || grant_log[grant_log.size() - 3] === 32'h0) begin
            errors++;
            $display("FAIL wrap_fetch: fetches after redirect=%0d required >=3", grant_log.size() - base);
        end
        repeat (30) tick(1'b0, 1'b0, 32'h0);
        checks++;
        if (exp_pc[31:8] !== 24'h0) begin
            errors++;
            $display("FAIL wrap_stream: next pc=%h required a wrapped low address", exp_pc);
        end
    endtask

`ifdef IF_MISALIGN_CHK_EN
    task automatic test_misalign();
        bit found = 0;
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        do_reset(1'b0);
        repeat (4) tick(1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 32'h102);
        tick(1'b1, 1'b0, 32'h0);
        checks++;
        if (misalign !== 1'b1) begin errors++; $display("FAIL mis_pulse: got %b required 1", misalign); end
        tick(1'b1, 1'b0, 32'h0);
        checks++;
        if (misalign !== 1'b0) begin errors++; $display("FAIL mis_single: got %b required 0", misalign); end
        for (int i = 0; i < 30 && !found; i++) begin
            tick(1'b1, 1'b0, 32'h0);
            if (grant_log.size() > 0 && grant_log[grant_log.size() - 1] === 32'h100) found = 1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL mis_addr: aligned fetch 00000100 not seen"); end
    endtask
`endif

    task automatic test_random();
        int total = 0;
        gnt_pct = 70; lat_min = 1; lat_max = 3;
        do_reset(1'b0);
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                total += pops;
                do_reset(1'b0);
            end
            tick($urandom_range(99) < 30, $urandom_range(99) < 4, $urandom & 32'h0000_0FFF);
        end
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        repeat (40) tick(1'b0, 1'b0, 32'h0);
        total += pops;
        checks++;
        if (total < 50) begin errors++; $display("FAIL random_progress: pops=%0d required >=50", total); end
    endtask

    initial begin
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        test_reset();
        test_sequence();
        test_full();
        test_redirect_wait();
        test_redirect_req();
        test_back_to_back();
        test_wrap();
`ifdef IF_MISALIGN_CHK_EN
        test_misalign();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_prefetch_queue.md
IF_PREFETCH_QUEUE -- requirements
Module: if_prefetch_queue

Interface
REQ-001 Parameter BIT_WIDTH, default 32, SHALL set the address, data and instruction width.
REQ-002 Parameter DEPTH, default 4, SHALL set the queue entries and SHALL be a power of two, at least 2.
REQ-003 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address.
REQ-004 The ports SHALL be as follows:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  BIT_WIDTH  word-aligned fetch address.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  BIT_WIDTH  fetched instruction.
- redirect  in  1  taken branch or jump from EX (PCSel).
- redirect_pc  in  BIT_WIDTH  branch target (ALU out).
- stall  in  1  hazard-unit hold; the head entry is not consumed.
- if_valid  out  1  head entry valid.
- if_pc  out  BIT_WIDTH  PC of the head entry.
- if_inst  out  BIT_WIDTH  instruction of the head entry.
- misalign  out  1  present only with IF_MISALIGN_CHK_EN.

Function
REQ-005 The block SHALL allow at most one memory transaction outstanding.
REQ-006 The fetch FSM SHALL have the states IDLE, REQ, WAIT and DROP.
REQ-007 Transitions SHALL be: IDLE->REQ when count<DEPTH; REQ->WAIT on imem_gnt; WAIT->IDLE on imem_rvalid.
REQ-008 In REQ, imem_req SHALL be 1 and imem_addr SHALL be held stable until imem_gnt.
REQ-009 On grant, fetch_pc SHALL advance by 4, wrapping modulo 2^BIT_WIDTH.
REQ-010 In WAIT, imem_rvalid SHALL push {req_pc, imem_rdata} into the queue; space is guaranteed because issue requires count<DEPTH.
REQ-011 A pop SHALL occur when if_valid=1, stall=0 and redirect=0.
- Push and pop in the same cycle SHALL leave count unchanged.
REQ-012 if_valid SHALL equal (count!=0); if_pc and if_inst SHALL show the head entry with no combinational path from imem_rdata.
REQ-013 Minimum latency from imem_rvalid in cycle N SHALL be if_valid=1 in cycle N+1.
REQ-014 Redirect SHALL take priority over push and pop. On redirect:
- the queue is flushed to count=0 next cycle;
- fetch_pc <= {redirect_pc[BIT_WIDTH-1:2],2'b00};
- IDLE goes to REQ when count<DEPTH, which always holds after the flush;
- WAIT goes to DROP;
- REQ keeps its address until grant, then goes to DROP.
REQ-015 In DROP, the next imem_rvalid SHALL be discarded, and the state SHALL then go to IDLE.
REQ-016 A redirect while in DROP SHALL update fetch_pc only.
REQ-017 When the queue is full (count=DEPTH), no new request SHALL issue; stall=1 SHALL hold all queue contents.
REQ-018 When the queue is empty, if_valid SHALL be 0 and if_pc/if_inst SHALL hold their last values.

Reset
REQ-019 While rst_n=0, the state SHALL be IDLE, count=0, fetch_pc=RESET_PC, and imem_req, if_valid and misalign SHALL be 0.
REQ-020 imem_addr, if_pc and if_inst SHALL reset to 0.
REQ-021 Reset asserted mid-transaction SHALL abandon it; an imem_rvalid in the first cycle after reset release SHALL be ignored.
REQ-022 The first imem_req SHALL assert in the first cycle after rst_n rises.

Configuration
REQ-023 With IF_MISALIGN_CHK_EN defined:
- a redirect with redirect_pc[1:0]!=0 SHALL pulse misalign for exactly one cycle, in the cycle after the redirect;
- the fetch SHALL still use the aligned address.
REQ-024 Without IF_MISALIGN_CHK_EN, the misalign port and its logic SHALL be absent, and redirect_pc[1:0] SHALL be ignored.

Structure
REQ-025 A shared package rv_pkg SHALL hold:
- the XLEN constant;
- the fetch-state enum (IDLE, REQ, WAIT, DROP);
- the default RESET_PC constant.
REQ-026 Storage SHALL be one sub-module, if_fifo: synchronous, DEPTH x (2*BIT_WIDTH), with push, pop, flush, count, and pointers that wrap at DEPTH.

Verification
REQ-027 Reset scenario: release reset with gnt=1 and rvalid one cycle after gnt -> imem_addr sequence 0x0,0x4,0x8; first if_valid with if_pc=0x0.
REQ-028 Full queue: hold stall=1 for 20 cycles -> count saturates at 4, imem_req=0, head stays if_pc=0x0.
REQ-029 Redirect while waiting: in WAIT, redirect=1 with redirect_pc=0x100 -> the pending rdata is dropped, next imem_addr=0x100, if_valid=0 until 0x100 returns.
REQ-030 Redirect while requesting: in REQ at addr 0x8 with gnt=0 for 3 cycles, redirect to 0x40 -> addr 0x8 held until gnt, response discarded, then request 0x40.
REQ-031 Simultaneous events: push and pop in the same cycle at count=2 -> count stays 2 and order is preserved.
REQ-032 Misalign check (macro on): redirect_pc=0x102 -> misalign=1 for one cycle, fetch address 0x100.
